// File: rtl/phase_driver.sv
// phase_driver
//   Per-transducer square-wave generator. A shared carrier counter is
//   compared against a per-channel phase offset to produce NUM_CHANNELS
//   50%-duty drive signals, all gated by the modulation block's output.
//   Phase values are written into a shadow bank and copied to the active
//   bank only at a carrier-period boundary, so the array never sees a
//   partially updated phase pattern.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   mod_in         modulation gate (1 = drive enabled), same clock domain
//   phase_wr_en    write strobe for the shadow phase bank
//   phase_wr_addr  channel index for the write (out-of-range ignored)
//   phase_wr_data  phase value in ticks
//   phase_commit   request to copy shadow -> active at the next boundary
//   commit_pending high from the commit request until the copy is done
//   period_start   one-cycle pulse in the cycle phase_cnt first reads 0
//   drive_out      registered, gated per-channel drive
module phase_driver #(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned PHASE_BITS   = 8,
    parameter int unsigned TICK_DIV     = 5,
    localparam int unsigned ADDR_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mod_in,
    input  logic                    phase_wr_en,
    input  logic [ADDR_BITS-1:0]    phase_wr_addr,
    input  logic [PHASE_BITS-1:0]   phase_wr_data,
    input  logic                    phase_commit,
    output logic                    commit_pending,
    output logic                    period_start,
    output logic [NUM_CHANNELS-1:0] drive_out
);

    localparam int unsigned TICK_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(TICK_DIV - 1);

    logic [TICK_BITS-1:0]  tick_cnt;
    logic [PHASE_BITS-1:0] phase_cnt;
    logic [PHASE_BITS-1:0] shadow [NUM_CHANNELS];
    logic [PHASE_BITS-1:0] active [NUM_CHANNELS];
    logic [PHASE_BITS-1:0] rel    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] raw;
    logic tick;
    logic boundary;
    logic do_copy;

    // With TICK_DIV=1, TICK_LAST is 0 and tick_cnt never leaves 0, so tick stays high.
    assign tick     = (tick_cnt == TICK_LAST);
    assign boundary = tick && (phase_cnt == '1);
    assign do_copy  = boundary && (commit_pending || phase_commit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt     <= '0;
            phase_cnt    <= '0;
            period_start <= 1'b0;
        end else begin
            if (tick) begin
                tick_cnt  <= '0;
                phase_cnt <= phase_cnt + PHASE_BITS'(1);
            end else begin
                tick_cnt  <= tick_cnt + TICK_BITS'(1);
            end
            period_start <= boundary;
        end
    end

    // Shadow writes. The loop only covers real channels, so addresses
    // at or beyond NUM_CHANNELS match nothing and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else if (phase_wr_en) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                if (phase_wr_addr == ADDR_BITS'(i)) begin
                    shadow[i] <= phase_wr_data;
                end
            end
        end
    end

    // Copy uses the pre-edge shadow values, so a write landing in the
    // boundary cycle is held back until the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_pending <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                active[i] <= '0;
            end
        end else if (do_copy) begin
            commit_pending <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                active[i] <= shadow[i];
            end
        end else if (phase_commit) begin
            commit_pending <= 1'b1;
        end
    end

    // A channel is high for the first half of its own shifted period.
    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            rel[i] = phase_cnt - active[i];
            raw[i] = ~rel[i][PHASE_BITS-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drive_out <= '0;
        end else begin
            drive_out <= raw & {NUM_CHANNELS{mod_in}};
        end
    end

endmodule

// File: tb/tb_phase_driver.sv
// tb_phase_driver
//   Directed bench for phase_driver with NUM_CHANNELS=4, PHASE_BITS=4,
//   TICK_DIV=2 (32 clk carrier period). n counts clock edges since reset
//   release; expected waveforms are derived from n and the phase set the
//   bench believes is active, with hand-computed spot values on top.
module tb_phase_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       mod_in;
    logic       phase_wr_en;
    logic [1:0] phase_wr_addr;
    logic [3:0] phase_wr_data;
    logic       phase_commit;
    logic       commit_pending;
    logic       period_start;
    logic [3:0] drive_out;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned n     = 0;
    int unsigned exp_ph [4];

    phase_driver #(
        .NUM_CHANNELS(4),
        .PHASE_BITS(4),
        .TICK_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mod_in(mod_in),
        .phase_wr_en(phase_wr_en),
        .phase_wr_addr(phase_wr_addr),
        .phase_wr_data(phase_wr_data),
        .phase_commit(phase_commit),
        .commit_pending(commit_pending),
        .period_start(period_start),
        .drive_out(drive_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog n=%0d got=timeout exp=finish", n);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    // Drive expected after the next edge: carrier position after edge cyc
    // is (cyc/2) mod 16; a channel is high while (pos - phase) mod 16 < 8.
    function automatic logic [3:0] exp_drive(input int unsigned cyc, input logic m);
        logic [3:0] e;
        int unsigned pc;
        pc = (cyc / 2) % 16;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            e[i] = m && (((pc + 16 - exp_ph[i]) % 16) < 8);
        end
        return e;
    endfunction

    task automatic step_chk();
        logic [3:0] e;
        e = exp_drive(n, mod_in);
        @(posedge clk);
        #1;
        n++;
        check("drive", {28'd0, drive_out}, {28'd0, e});
        check("period_start", {31'd0, period_start}, {31'd0, (n % 32) == 0});
    endtask

    task automatic run_to(input int unsigned target);
        while (n < target) step_chk();
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        phase_wr_en   = 1'b1;
        phase_wr_addr = a;
        phase_wr_data = d;
        step_chk();
        phase_wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mod_in = 1'b0; phase_wr_en = 1'b0;
        phase_wr_addr = '0; phase_wr_data = '0; phase_commit = 1'b0;
        for (int i = 0; i < 4; i++) exp_ph[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_drive", {28'd0, drive_out}, 32'd0);
        check("rst_ps", {31'd0, period_start}, 32'd0);
        check("rst_pend", {31'd0, commit_pending}, 32'd0);
        rst = 1'b0; n = 0; mod_in = 1'b1;

        // all phases 0
        run_to(16);  check("hi_16", {28'd0, drive_out}, 32'hF);
        step_chk();  check("lo_17", {28'd0, drive_out}, 32'h0);
        run_to(32);  check("ps_32", {31'd0, period_start}, 32'd1);
        step_chk();  check("rise_33", {28'd0, drive_out}, 32'hF);
        run_to(64);

        // stagger 4/8/12 committed mid-period
        wr(2'd1, 4'd4); wr(2'd2, 4'd8); wr(2'd3, 4'd12);
        run_to(80);
        phase_commit = 1'b1; step_chk(); phase_commit = 1'b0;
        check("pend_set", {31'd0, commit_pending}, 32'd1);
        run_to(95);  check("pend_hold", {31'd0, commit_pending}, 32'd1);
        step_chk();  check("pend_clr", {31'd0, commit_pending}, 32'd0);
        exp_ph[1] = 4; exp_ph[2] = 8; exp_ph[3] = 12;
        run_to(104); check("stag_104", {28'd0, drive_out}, 32'h9);
        step_chk();  check("stag_105", {28'd0, drive_out}, 32'h3);
        run_to(128);

        // uncommitted write is invisible, then committed
        wr(2'd2, 4'd3);
        run_to(160);
        phase_commit = 1'b1; step_chk(); phase_commit = 1'b0;
        check("pend2_set", {31'd0, commit_pending}, 32'd1);
        run_to(191); check("pend2_hold", {31'd0, commit_pending}, 32'd1);
        step_chk();  check("pend2_clr", {31'd0, commit_pending}, 32'd0);
        exp_ph[2] = 3;
        run_to(198); check("ch2_198", {28'd0, drive_out}, 32'h9);
        step_chk();  check("ch2_199", {28'd0, drive_out}, 32'hD);
        run_to(224);
        wr(2'd1, 4'd6);
        run_to(255);

        // commit and write in the boundary cycle
        phase_commit = 1'b1; phase_wr_en = 1'b1; phase_wr_addr = 2'd0; phase_wr_data = 4'd5;
        step_chk();
        phase_commit = 1'b0; phase_wr_en = 1'b0;
        check("bnd_pend", {31'd0, commit_pending}, 32'd0);
        exp_ph[1] = 6;
        step_chk();  check("bnd_pend2", {31'd0, commit_pending}, 32'd0);
        run_to(262); check("ch0_kept", {28'd0, drive_out}, 32'h9);
        run_to(288);

        // gate for 10 clk mid-high
        run_to(292); check("pre_gate", {28'd0, drive_out}, 32'h9);
        mod_in = 1'b0;
        step_chk();  check("gated", {28'd0, drive_out}, 32'h0);
        run_to(302);
        mod_in = 1'b1;
        step_chk();  check("ungated", {28'd0, drive_out}, 32'h7);
        run_to(320);

        // reset with a pending commit
        run_to(330);
        phase_commit = 1'b1; step_chk(); phase_commit = 1'b0;
        check("pend3_set", {31'd0, commit_pending}, 32'd1);
        run_to(340); check("pre_rst", {28'd0, drive_out}, 32'h6);
        rst = 1'b1;
        #1;
        check("arst_drive", {28'd0, drive_out}, 32'd0);
        check("arst_ps", {31'd0, period_start}, 32'd0);
        check("arst_pend", {31'd0, commit_pending}, 32'd0);
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0; n = 0;
        for (int i = 0; i < 4; i++) exp_ph[i] = 0;
        run_to(10);
        phase_commit = 1'b1; step_chk(); phase_commit = 1'b0;
        check("pend4_set", {31'd0, commit_pending}, 32'd1);
        run_to(31);  check("pend4_hold", {31'd0, commit_pending}, 32'd1);
        step_chk();  check("pend4_clr", {31'd0, commit_pending}, 32'd0);
        check("ps_after_rst", {31'd0, period_start}, 32'd1);
        step_chk();  check("zero_ph_33", {28'd0, drive_out}, 32'hF);
        run_to(48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
